// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The producer/consumer side takes master, the FIFO takes slave.
interface sync_fifo_flags_if #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 3
);
   logic             clr;
   logic             winc;
   logic [DSIZE-1:0] wdata;
   logic             rinc;
   logic [DSIZE-1:0] rdata;
   logic             wfull;
   logic             rempty;
   logic             walmost_full;
   logic             ralmost_empty;
   logic [ASIZE:0]   count;
   logic             overflow;
   logic             underflow;

   modport master (
      output clr, winc, wdata, rinc,
      input  rdata, wfull, rempty, walmost_full,
      input  ralmost_empty, count, overflow, underflow
   );

   modport slave (
      input  clr, winc, wdata, rinc,
      output rdata, wfull, rempty, walmost_full,
      output ralmost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact registered flags, occupancy, sticky errors, flush.
// Define FIFO_FWFT_EN for first-word fall-through read data.
module sync_fifo_flags #(
   parameter int DSIZE      = 8,
   parameter int ASIZE      = 3,
   parameter int AFULL_LVL  = (1 << ASIZE) - 1,
   parameter int AEMPTY_LVL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   sync_fifo_flags_if.slave bus
);
   localparam int DEPTH = 1 << ASIZE;
   localparam logic [ASIZE:0] L_DEPTH  = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] L_AFULL  = (ASIZE+1)'(AFULL_LVL);
   localparam logic [ASIZE:0] L_AEMPTY = (ASIZE+1)'(AEMPTY_LVL);

   if (AFULL_LVL < 0 || AFULL_LVL > DEPTH ||
       AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH) begin : g_bad_cfg
      $error("sync_fifo_flags: threshold outside 0..DEPTH");
   end

   logic [DSIZE-1:0] r_mem [DEPTH];
   logic [ASIZE:0]   r_wptr;
   logic [ASIZE:0]   r_rptr;
   logic [ASIZE:0]   r_count;
   logic             r_wfull;
   logic             r_rempty;
   logic             r_afull;
   logic             r_aempty;
   logic             r_ovf;
   logic             r_udf;

   logic             w_rd_ok;
   logic             w_wr_ok;
   logic [ASIZE:0]   w_cnt_nx;
   logic [ASIZE-1:0] w_waddr;
   logic [ASIZE-1:0] w_raddr;

   assign w_rd_ok = bus.rinc & ~r_rempty;
   assign w_wr_ok = bus.winc & (~r_wfull | w_rd_ok);
   assign w_waddr = r_wptr[ASIZE-1:0];
   assign w_raddr = r_rptr[ASIZE-1:0];

   // flush folds into the next count so flags stay exact on that edge too
   always_comb begin
      w_cnt_nx = r_count + (ASIZE+1)'(w_wr_ok) - (ASIZE+1)'(w_rd_ok);
      if (bus.clr) begin
         w_cnt_nx = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_wfull  <= 1'b0;
         r_rempty <= 1'b1;
         r_afull  <= (L_AFULL == '0);
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         r_count  <= w_cnt_nx;
         r_wfull  <= (w_cnt_nx == L_DEPTH);
         r_rempty <= (w_cnt_nx == '0);
         r_afull  <= (w_cnt_nx >= L_AFULL);
         r_aempty <= (w_cnt_nx <= L_AEMPTY);
         if (bus.clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
         end else begin
            if (w_wr_ok) begin
               r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
               r_rptr <= r_rptr + 1'b1;
            end
            if (bus.winc && !w_wr_ok) begin
               r_ovf <= 1'b1;
            end
            if (bus.rinc && r_rempty) begin
               r_udf <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!bus.clr && w_wr_ok) begin
         r_mem[w_waddr] <= bus.wdata;
      end
   end

`ifdef FIFO_FWFT_EN
   assign bus.rdata = r_rempty ? '0 : r_mem[w_raddr];
`else
   logic [DSIZE-1:0] r_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (!bus.clr && w_rd_ok) begin
         r_rdata <= r_mem[w_raddr];
      end
   end

   assign bus.rdata = r_rdata;
`endif

   assign bus.wfull         = r_wfull;
   assign bus.rempty        = r_rempty;
   assign bus.walmost_full  = r_afull;
   assign bus.ralmost_empty = r_aempty;
   assign bus.count         = r_count;
   assign bus.overflow      = r_ovf;
   assign bus.underflow     = r_udf;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed vector bench for sync_fifo_flags (DEPTH=8, AFULL=7, AEMPTY=1).
// Define FIFO_FWFT_EN to run the fall-through data checks.
module tb_sync_fifo_flags;
   typedef struct {
      logic       clr;
      logic       winc;
      logic       rinc;
      logic [7:0] wdata;
      logic [7:0] erd;
      logic       crd;
      int         ecnt;
      logic       eovf;
      logic       eudf;
   } vec_t;

`ifdef FIFO_FWFT_EN
   localparam logic STD = 1'b0;
`else
   localparam logic STD = 1'b1;
`endif

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;
   vec_t vq[$];

   sync_fifo_flags_if #(.DSIZE(8), .ASIZE(3)) bus ();

   sync_fifo_flags #(
      .DSIZE(8), .ASIZE(3), .AFULL_LVL(7), .AEMPTY_LVL(1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic chk_state(input string tag, input logic [7:0] erd, input logic crd,
                            input int ecnt, input logic eovf, input logic eudf);
      chk({tag, " count"}, 32'(bus.count), 32'(ecnt));
      chk({tag, " wfull"}, 32'(bus.wfull), 32'(ecnt == 8));
      chk({tag, " rempty"}, 32'(bus.rempty), 32'(ecnt == 0));
      chk({tag, " afull"}, 32'(bus.walmost_full), 32'(ecnt >= 7));
      chk({tag, " aempty"}, 32'(bus.ralmost_empty), 32'(ecnt <= 1));
      chk({tag, " ovf"}, 32'(bus.overflow), 32'(eovf));
      chk({tag, " udf"}, 32'(bus.underflow), 32'(eudf));
      if (crd) chk({tag, " rdata"}, 32'(bus.rdata), 32'(erd));
   endtask

   task automatic step(input logic c, input logic w, input logic r, input logic [7:0] wd);
      bus.clr   = c;
      bus.winc  = w;
      bus.rinc  = r;
      bus.wdata = wd;
      @(posedge clk);
      #1;
      bus.clr  = 1'b0;
      bus.winc = 1'b0;
      bus.rinc = 1'b0;
   endtask

   function automatic void add(input logic c, input logic w, input logic r,
                               input logic [7:0] wd, input logic [7:0] erd,
                               input int ecnt, input logic eovf, input logic eudf);
      vec_t v;
      v.clr = c; v.winc = w; v.rinc = r; v.wdata = wd;
      v.erd = erd; v.crd = STD; v.ecnt = ecnt;
      v.eovf = eovf; v.eudf = eudf;
      vq.push_back(v);
   endfunction

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      bus.clr = 1'b0;
      bus.winc = 1'b0;
      bus.rinc = 1'b0;
      bus.wdata = 8'h00;

      // fill to full, then one dropped write
      for (int k = 1; k <= 8; k++) add(0, 1, 0, 8'(k), 8'h00, k, 0, 0);
      add(0, 1, 0, 8'hAA, 8'h00, 8, 1, 0);
      // drain in order, then one underflow
      for (int k = 1; k <= 8; k++) add(0, 0, 1, 8'h00, 8'(k), 8 - k, 1, 0);
      add(0, 0, 1, 8'h00, 8'h08, 0, 1, 1);
      add(1, 0, 0, 8'h00, 8'h08, 0, 0, 0);
      // full with simultaneous write and read
      for (int k = 0; k < 8; k++) add(0, 1, 0, 8'(8'h10 + k), 8'h08, k + 1, 0, 0);
      add(0, 1, 1, 8'h55, 8'h10, 8, 0, 0);
      for (int k = 1; k < 8; k++) add(0, 0, 1, 8'h00, 8'(8'h10 + k), 8 - k, 0, 0);
      add(0, 0, 1, 8'h00, 8'h55, 0, 0, 0);
      // empty with simultaneous write and read, then wrap traffic
      add(0, 1, 1, 8'h33, 8'h55, 1, 0, 1);
      add(0, 0, 1, 8'h00, 8'h33, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         add(0, 1, 0, 8'(i), (i == 0) ? 8'h33 : 8'(i - 1), 1, 0, 1);
         add(0, 0, 1, 8'h00, 8'(i), 0, 0, 1);
      end
      // flush, and flush winning over write/read
      for (int k = 0; k < 3; k++) add(0, 1, 0, 8'(8'hC0 + k), 8'd19, k + 1, 0, 1);
      add(1, 0, 0, 8'h00, 8'd19, 0, 0, 0);
      add(0, 1, 0, 8'h77, 8'd19, 1, 0, 0);
      add(1, 1, 1, 8'h78, 8'd19, 0, 0, 0);

      #12;
      chk_state("reset", 8'h00, 1'b1, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].clr, vq[i].winc, vq[i].rinc, vq[i].wdata);
         chk_state($sformatf("v%0d", i), vq[i].erd, vq[i].crd,
                   vq[i].ecnt, vq[i].eovf, vq[i].eudf);
      end

      // async reset in the middle of a write
      step(0, 0, 1, 8'h00);
      step(0, 1, 0, 8'hD0);
      step(0, 1, 0, 8'hD1);
      chk_state("pre_rst", 8'd19, STD, 2, 0, 1);
      bus.winc = 1'b1;
      bus.wdata = 8'hD2;
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("async_rst", 8'h00, 1'b1, 0, 0, 0);
      bus.winc = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_state("post_rst", 8'h00, 1'b1, 0, 0, 0);

`ifdef FIFO_FWFT_EN
      step(0, 1, 0, 8'h11);
      chk_state("fwft_w1", 8'h11, 1'b1, 1, 0, 0);
      step(0, 1, 0, 8'h22);
      chk_state("fwft_w2", 8'h11, 1'b1, 2, 0, 0);
      step(0, 0, 1, 8'h00);
      chk_state("fwft_r1", 8'h22, 1'b1, 1, 0, 0);
      step(0, 0, 1, 8'h00);
      chk_state("fwft_r2", 8'h00, 1'b1, 0, 0, 0);
`else
      step(0, 1, 0, 8'hE5);
      chk_state("std_w", 8'h00, 1'b1, 1, 0, 0);
      step(0, 0, 1, 8'h00);
      chk_state("std_r", 8'hE5, 1'b1, 0, 0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
